// File: rtl/hex_dumper.sv
// Streams a memory byte range as ASCII Intel HEX: data records (type 00) followed by one EOF record.
// Memory reads go through a one-cycle-latency read port. Characters leave on a byte-wide valid/ready stream.
module hex_dumper #(
  parameter int RECORD_BYTES = 16
) (
  input  logic        clk_74a,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] start_addr,
  input  logic [16:0] length,
  output logic        busy,
  output logic        done,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic [3:0]  dbg_state
);

  // Stream handshake: a byte moves when out_valid and out_ready are both high on a clk_74a edge.
  // Once out_valid is raised, out_data holds its value and out_valid stays high until that handshake.
  typedef enum logic [3:0] {
    S_IDLE, S_COLON, S_LEN, S_ADDR, S_TYPE, S_FETCH, S_WAIT,
    S_DATA, S_CKSUM, S_CR, S_LF, S_EOF, S_FIN
  } state_t;

  state_t      state;
  logic [1:0]  nib;
  logic [3:0]  eof_idx;
  logic [15:0] addr;
  logic [16:0] remaining;
  logic [7:0]  rec_len;
  logic [7:0]  rec_cnt;
  logic [7:0]  sum;
  logic [7:0]  data_byte;

  logic        fire;
  logic [7:0]  sum_with_data;
  logic [7:0]  ck_final;
  logic [7:0]  ck_cur;
  logic [7:0]  rec_len_start;
  logic [7:0]  rec_len_next;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  function automatic logic [7:0] clip_len(input logic [16:0] r);
    return (r > 17'(RECORD_BYTES)) ? 8'(RECORD_BYTES) : r[7:0];
  endfunction

  function automatic logic [3:0] addr_nib(input logic [15:0] a, input logic [1:0] k);
    case (k)
      2'd0:    return a[15:12];
      2'd1:    return a[11:8];
      2'd2:    return a[7:4];
      default: return a[3:0];
    endcase
  endfunction

  // Fixed EOF record ":00000001FF" CR LF, indexed 0..12.
  function automatic logic [7:0] eof_char(input logic [3:0] i);
    case (i)
      4'd0:        return 8'h3A;
      4'd8:        return 8'h31;
      4'd9, 4'd10: return 8'h46;
      4'd11:       return 8'h0D;
      4'd12:       return 8'h0A;
      default:     return 8'h30;
    endcase
  endfunction

  assign fire          = out_valid & out_ready;
  assign sum_with_data = sum + data_byte;
  assign ck_final      = 8'h00 - sum_with_data;
  assign ck_cur        = 8'h00 - sum;
  assign rec_len_start = clip_len(length);
  assign rec_len_next  = clip_len(remaining);
  assign dbg_state     = state;

  // The next character is loaded on the same edge that accepts the current one, so header and
  // checksum fields sustain one character per cycle.
  always_ff @(posedge clk_74a) begin
    if (reset) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_rd    <= 1'b0;
      mem_addr  <= 16'h0000;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      nib       <= 2'd0;
      eof_idx   <= 4'd0;
      addr      <= 16'h0000;
      remaining <= 17'd0;
      rec_len   <= 8'd0;
      rec_cnt   <= 8'd0;
      sum       <= 8'd0;
      data_byte <= 8'd0;
    end else begin
      done   <= 1'b0;
      mem_rd <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            addr      <= start_addr;
            remaining <= length;
            out_valid <= 1'b1;
            out_data  <= 8'h3A;
            nib       <= 2'd0;
            eof_idx   <= 4'd0;
            if (length == 17'd0) begin
              state <= S_EOF;
            end else begin
              rec_len <= rec_len_start;
              rec_cnt <= rec_len_start;
              state   <= S_COLON;
            end
          end
        end
        S_COLON: begin
          if (fire) begin
            sum      <= 8'd0;
            nib      <= 2'd0;
            out_data <= hex_char(rec_len[7:4]);
            state    <= S_LEN;
          end
        end
        S_LEN: begin
          if (fire) begin
            if (nib == 2'd0) begin
              nib      <= 2'd1;
              out_data <= hex_char(rec_len[3:0]);
            end else begin
              sum      <= sum + rec_len;
              nib      <= 2'd0;
              out_data <= hex_char(addr[15:12]);
              state    <= S_ADDR;
            end
          end
        end
        S_ADDR: begin
          if (fire) begin
            if (nib != 2'd3) begin
              nib      <= nib + 2'd1;
              out_data <= hex_char(addr_nib(addr, nib + 2'd1));
            end else begin
              sum      <= sum + addr[15:8] + addr[7:0];
              nib      <= 2'd0;
              out_data <= 8'h30;
              state    <= S_TYPE;
            end
          end
        end
        S_TYPE: begin
          if (fire) begin
            if (nib == 2'd0) begin
              nib      <= 2'd1;
              out_data <= 8'h30;
            end else begin
              nib       <= 2'd0;
              out_valid <= 1'b0;
              mem_rd    <= 1'b1;
              mem_addr  <= addr;
              state     <= S_FETCH;
            end
          end
        end
        S_FETCH: state <= S_WAIT;
        S_WAIT: begin
          data_byte <= mem_data;
          out_data  <= hex_char(mem_data[7:4]);
          out_valid <= 1'b1;
          nib       <= 2'd0;
          state     <= S_DATA;
        end
        S_DATA: begin
          if (fire) begin
            if (nib == 2'd0) begin
              nib      <= 2'd1;
              out_data <= hex_char(data_byte[3:0]);
            end else begin
              nib       <= 2'd0;
              sum       <= sum_with_data;
              addr      <= addr + 16'd1;
              remaining <= remaining - 17'd1;
              rec_cnt   <= rec_cnt - 8'd1;
              if (rec_cnt != 8'd1) begin
                out_valid <= 1'b0;
                mem_rd    <= 1'b1;
                mem_addr  <= addr + 16'd1;
                state     <= S_FETCH;
              end else begin
                out_data <= hex_char(ck_final[7:4]);
                state    <= S_CKSUM;
              end
            end
          end
        end
        S_CKSUM: begin
          if (fire) begin
            if (nib == 2'd0) begin
              nib      <= 2'd1;
              out_data <= hex_char(ck_cur[3:0]);
            end else begin
              nib      <= 2'd0;
              out_data <= 8'h0D;
              state    <= S_CR;
            end
          end
        end
        S_CR: begin
          if (fire) begin
            out_data <= 8'h0A;
            state    <= S_LF;
          end
        end
        S_LF: begin
          if (fire) begin
            out_data <= 8'h3A;
            if (remaining != 17'd0) begin
              rec_len <= rec_len_next;
              rec_cnt <= rec_len_next;
              state   <= S_COLON;
            end else begin
              eof_idx <= 4'd0;
              state   <= S_EOF;
            end
          end
        end
        S_EOF: begin
          if (fire) begin
            if (eof_idx == 4'd12) begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              state     <= S_FIN;
            end else begin
              eof_idx  <= eof_idx + 4'd1;
              out_data <= eof_char(eof_idx + 4'd1);
            end
          end
        end
        S_FIN: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
